// File: rtl/addsub_pkg.sv
// Shared types for the bit-serial add/subtract sequencer.
package addsub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/serial_addsub_ctrl_fa_cell.sv
// Combinational 1-bit full adder cell, time-shared by the serial sequencer.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit add/subtract sequencer, LSB first, one fa_cell.
// Define SERIAL_ADDSUB_OVF_EN to add the registered signed-overflow output.
module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  state_e           state;
  logic [WIDTH-1:0] op_a, op_b;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum, fa_cout;
  logic             last_bit;

  fa_cell u_fa (
    .a   (op_a[0]),
    .b   (op_b[0]),
    .cin (carry),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtract as A + ~B + 1: the +1 rides in on the carry FF.
            op_a  <= a;
            op_b  <= (sub == OP_SUB) ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          op_a   <= op_a >> 1;
          op_b   <= op_b >> 1;
          carry  <= fa_cout;
          cnt    <= cnt + 1'b1;
          result <= {fa_sum, result[WIDTH-1:1]};
          if (last_bit) begin
            carry_out <= fa_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
            // carry FF holds the carry into the MSB at this point.
            overflow  <= carry ^ fa_cout;
`endif
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
- Bit-serial add/subtract sequencer that time-shares one 1-bit full-adder cell across a WIDTH-bit operation, LSB first.
- Owns the operand shift registers, the carry flip-flop, the bit counter and a start/busy/done handshake.
- Sits between a requesting unit and the adder cell. Gives area-cheap arithmetic for wide operands at the cost of WIDTH cycles per operation.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden).

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  0 = A+B, 1 = A-B; captured with start.
- a  in  WIDTH  operand A; captured with start.
- b  in  WIDTH  operand B; captured with start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when result is valid.
- result  out  WIDTH  sum/difference; held until next accepted start.
- carry_out  out  1  final carry (sub: 1 = no borrow, a>=b unsigned).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, carry_out=0, counter=0, carry FF=0, operand regs=0. Reset mid-operation aborts with no done pulse.
- Single clock, one reset, no other async paths. Outputs are registered.
- FSM states IDLE, RUN, DONE:
  - IDLE: start=1 at edge -> load opA=a, opB=(sub ? ~b : b), carry=sub, cnt=0 -> RUN. start=0 -> stay.
  - RUN: each edge feeds the cell with opA[0], opB[0], carry. Sum shifts into result MSB (result shifts right). opA/opB shift right, carry<=cell carry, cnt++. When cnt==WIDTH-1 at the edge, go to DONE, with the final bit and carry_out registered on that same edge.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Latency: start accepted on edge N; done high during cycle after edge N+WIDTH. Next start is accepted no earlier than edge N+WIDTH+2.
- start while busy (RUN/DONE): ignored, never queued. Inputs a, b and sub are don't-care except at the accept edge.
- result and carry_out update only during RUN. They are stable from done until the next accepted start.
- Arithmetic is modulo 2^WIDTH. Subtraction uses two's complement (invert B, carry-in 1).

Optional Feature:
- Macro SERIAL_ADDSUB_OVF_EN.
- Defined: adds output port overflow (1 bit, reset 0). It is the signed overflow (carry into MSB XOR carry out of MSB), registered on the final RUN edge and held like result.
- Undefined: port absent; no extra logic.

Decomposition:
- Shared package addsub_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - op encoding constants OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module, fa_cell: purely combinational 1-bit full adder (a, b, cin -> sum, cout), instantiated once.
- FSM, counter and shift registers stay in serial_addsub_ctrl.

Test Plan:
- WIDTH=8, add 0x5A+0x33 -> done pulse after 8 RUN cycles; result=0x8D, carry_out=0; busy high 9 cycles.
- Add 0xFF+0x01 -> result=0x00, carry_out=1. With SERIAL_ADDSUB_OVF_EN: 0x7F+0x01 -> result=0x80, overflow=1; 0xFF+0x01 -> overflow=0.
- Sub 0x10-0x01 -> result=0x0F, carry_out=1. Sub 0x01-0x02 -> result=0xFF, carry_out=0.
- Hold start=1 continuously with changing a/b -> only the operation accepted in IDLE executes. Back-to-back operations are spaced 10 edges apart, with done pulses exactly 1 cycle wide.
- Drop rst_n at RUN cycle 4 -> all outputs 0 immediately (async). No done pulse. After release, a fresh 0x02+0x03 gives result=0x05.
- Sweep 256 random (a, b, sub) -> result and carry_out match the reference model; result is stable from done until the next accepted start.
